// File: rtl/tlc_pkg.sv
// tlc_pkg: light-state encoding shared by the traffic-light controller and
// the lamp driver.
//   tlc_state_e       3-bit light state (OFF, BLANK, RED, YELLOW, GREEN)
//   TLC_FB_TRIP_CYC   consecutive lamp-feedback mismatch cycles before a trip
//   tlc_code_valid()  true for the five defined state codes
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_BLANK  = 3'd1,
        ST_RED    = 3'd2,
        ST_YELLOW = 3'd3,
        ST_GREEN  = 3'd4
    } tlc_state_e;

    localparam int unsigned TLC_FB_TRIP_CYC = 4;

    function automatic logic tlc_code_valid(input logic [2:0] code);
        return code <= 3'd4;
    endfunction

endpackage

// File: rtl/tlc_blink_gen.sv
// tlc_blink_gen: square-wave generator for the BLANK (flashing yellow) state.
//   clk, rst_n  clock, asynchronous active-low reset
//   enable      high while the applied state is BLANK
//   restart     one-cycle pulse on entry to BLANK; output restarts lit
//   half        cycles per half-period (0 behaves as 1), sampled live
//   blink       lamp phase, 1 = lit
module tlc_blink_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             restart,
    input  logic [CNT_W-1:0] half,
    output logic             blink
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_eff;

    assign half_eff = (half == '0) ? ONE : half;

    // >= rather than == so a live shrink of half cannot strand the counter
    // above the new terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            blink <= 1'b1;
        end else if (!enable) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (cnt >= half_eff - ONE) begin
            cnt   <= '0;
            blink <= ~blink;
        end else begin
            cnt   <= cnt + ONE;
        end
    end

endmodule

// File: rtl/tlc_lamp_drv.sv
// tlc_lamp_drv: applies requested light states to the red/yellow/green lamp
// drives, enforcing a minimum dwell per state, a forced YELLOW when leaving
// GREEN, and a flashing yellow for BLANK.
//   pclk, prst          clock, asynchronous active-low reset
//   state_in, state_vld requested state and its qualifier (last request wins)
//   min_dwell           minimum cycles an applied state is held (0 -> 1)
//   blink_half          BLANK half-period in cycles (0 -> 1)
//   fault_clr           clears the sticky fault flag
//   lamp_red/yel/grn    lamp drives, at most one lit
//   busy                pending request not yet applied
//   fault               sticky: invalid code sampled (or lamp feedback trip)
// Build option TLC_LAMP_FB_EN adds lamp_fb[2:0] ({red,yel,grn} sensed); four
// consecutive cycles of mismatch against the drives set fault and force BLANK.
module tlc_lamp_drv #(
    parameter int CNT_W = 16
) (
    input  logic             pclk,
    input  logic             prst,
    input  logic [2:0]       state_in,
    input  logic             state_vld,
    input  logic [CNT_W-1:0] min_dwell,
    input  logic [CNT_W-1:0] blink_half,
    input  logic             fault_clr,
`ifdef TLC_LAMP_FB_EN
    input  logic [2:0]       lamp_fb,
`endif
    output logic             lamp_red,
    output logic             lamp_yel,
    output logic             lamp_grn,
    output logic             busy,
    output logic             fault
);

    import tlc_pkg::*;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    tlc_state_e       pending, pending_nxt;
    tlc_state_e       cur, cur_nxt;
    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] dwell_eff;
    logic             dwell_met;
    logic             fault_nxt;
    logic             cur_chg;
    logic             blink_q;

    assign dwell_eff = (min_dwell == '0) ? ONE : min_dwell;
    assign dwell_met = dwell_cnt >= dwell_eff - ONE;

`ifdef TLC_LAMP_FB_EN
    logic [1:0] fb_cnt;
    logic       fb_mism;
    logic       fb_trip;

    assign fb_mism = lamp_fb != {lamp_red, lamp_yel, lamp_grn};
    // fb_cnt holds the number of prior consecutive mismatch cycles (saturating).
    assign fb_trip = fb_mism && (fb_cnt == 2'(TLC_FB_TRIP_CYC - 1));

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst)              fb_cnt <= '0;
        else if (!fb_mism)      fb_cnt <= '0;
        else if (fb_cnt != 2'd3) fb_cnt <= fb_cnt + 2'd1;
    end
`endif

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            pending   <= ST_RED;
            cur       <= ST_RED;
            dwell_cnt <= '0;
            fault     <= 1'b0;
        end else begin
            pending <= pending_nxt;
            cur     <= cur_nxt;
            fault   <= fault_nxt;
            if (cur_chg)              dwell_cnt <= '0;
            else if (dwell_cnt != '1) dwell_cnt <= dwell_cnt + ONE;
        end
    end

    always_comb begin
        pending_nxt = pending;
        fault_nxt   = fault;
        cur_nxt     = cur;

        if (fault_clr) fault_nxt = 1'b0;
        // An invalid code on the same edge as fault_clr keeps the flag set.
        if (state_vld) begin
            if (tlc_code_valid(state_in)) begin
                pending_nxt = tlc_state_e'(state_in);
            end else begin
                pending_nxt = ST_BLANK;
                fault_nxt   = 1'b1;
            end
        end
`ifdef TLC_LAMP_FB_EN
        if (fb_trip) begin
            pending_nxt = ST_BLANK;
            fault_nxt   = 1'b1;
        end
`endif

        // Leaving GREEN for anything but YELLOW passes through YELLOW, which
        // then has to serve its own full dwell before the real target.
        if (pending != cur && dwell_met) begin
            if (cur == ST_GREEN && pending != ST_YELLOW) cur_nxt = ST_YELLOW;
            else                                         cur_nxt = pending;
        end
    end

    assign cur_chg = cur_nxt != cur;
    assign busy    = pending != cur;

    tlc_blink_gen #(.CNT_W(CNT_W)) u_blink (
        .clk     (pclk),
        .rst_n   (prst),
        .enable  (cur == ST_BLANK),
        .restart (cur_chg && cur_nxt == ST_BLANK),
        .half    (blink_half),
        .blink   (blink_q)
    );

    always_comb begin
        lamp_red = 1'b0;
        lamp_yel = 1'b0;
        lamp_grn = 1'b0;
        case (cur)
            ST_RED:    lamp_red = 1'b1;
            ST_YELLOW: lamp_yel = 1'b1;
            ST_GREEN:  lamp_grn = 1'b1;
            ST_BLANK:  lamp_yel = blink_q;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_tlc_lamp_drv.sv
// tb_tlc_lamp_drv: directed vector table for request/dwell/forced-yellow
// behaviour, plus hand-written sequences for blink, fault and async reset.
module tb_tlc_lamp_drv;

    localparam int CNT_W = 16;

    logic             pclk;
    logic             prst;
    logic [2:0]       state_in;
    logic             state_vld;
    logic [CNT_W-1:0] min_dwell;
    logic [CNT_W-1:0] blink_half;
    logic             fault_clr;
    logic             lamp_red, lamp_yel, lamp_grn, busy, fault;

    int errors = 0;
    int checks = 0;

    tlc_lamp_drv #(.CNT_W(CNT_W)) dut (
        .pclk       (pclk),
        .prst       (prst),
        .state_in   (state_in),
        .state_vld  (state_vld),
        .min_dwell  (min_dwell),
        .blink_half (blink_half),
        .fault_clr  (fault_clr),
        .lamp_red   (lamp_red),
        .lamp_yel   (lamp_yel),
        .lamp_grn   (lamp_grn),
        .busy       (busy),
        .fault      (fault)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // exp = {red, yel, grn, busy, fault}
    typedef struct {
        logic [2:0]       st;
        logic             vld;
        logic [CNT_W-1:0] md;
        logic [4:0]       exp;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic [2:0] st, input logic vld,
                                input int md, input logic [4:0] exp);
        vec_t v;
        v.st  = st;
        v.vld = vld;
        v.md  = CNT_W'(md);
        v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk_lamps(input string name, input logic [4:0] exp);
        chk(name, {27'd0, lamp_red, lamp_yel, lamp_grn, busy, fault}, {27'd0, exp});
        chk({name, "_onehot"}, 32'(int'(lamp_red) + int'(lamp_yel) + int'(lamp_grn) <= 1), 32'd1);
    endtask

    initial begin
        // Reset -> YELLOW with min_dwell=3: yel on 3rd edge after release.
        tbl[0]  = mk(3'd3, 1'b1, 3, 5'b10010);
        tbl[1]  = mk(3'd0, 1'b0, 3, 5'b10010);
        tbl[2]  = mk(3'd0, 1'b0, 3, 5'b01000);
        // RED, GREEN, OFF back to back inside a dwell of 8: only OFF lands.
        tbl[3]  = mk(3'd2, 1'b1, 8, 5'b01010);
        tbl[4]  = mk(3'd4, 1'b1, 8, 5'b01010);
        tbl[5]  = mk(3'd0, 1'b1, 8, 5'b01010);
        for (int i = 6; i <= 9; i++) tbl[i] = mk(3'd0, 1'b0, 8, 5'b01010);
        tbl[10] = mk(3'd0, 1'b0, 8, 5'b00000);
        // OFF -> GREEN.
        tbl[11] = mk(3'd4, 1'b1, 3, 5'b00010);
        tbl[12] = mk(3'd0, 1'b0, 3, 5'b00010);
        tbl[13] = mk(3'd0, 1'b0, 3, 5'b00100);
        // GREEN dwell met, request RED: 5 cycles YELLOW, then RED.
        for (int i = 14; i <= 17; i++) tbl[i] = mk(3'd0, 1'b0, 5, 5'b00100);
        tbl[18] = mk(3'd2, 1'b1, 5, 5'b00110);
        for (int i = 19; i <= 23; i++) tbl[i] = mk(3'd0, 1'b0, 5, 5'b01010);
        tbl[24] = mk(3'd0, 1'b0, 5, 5'b10000);

        prst       = 1'b0;
        state_in   = 3'd0;
        state_vld  = 1'b0;
        min_dwell  = 16'd3;
        blink_half = 16'd4;
        fault_clr  = 1'b0;
        #12;
        chk_lamps("reset", 5'b10000);
        @(negedge pclk);
        prst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            state_in  = tbl[i].st;
            state_vld = tbl[i].vld;
            min_dwell = tbl[i].md;
            step();
            chk_lamps($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Invalid code 6 from RED: fault, pending BLANK, then BLANK applied.
        min_dwell = 16'd1;
        state_in  = 3'd6;
        state_vld = 1'b1;
        step();
        chk_lamps("inv6_req", 5'b10011);
        state_vld = 1'b0;
        state_in  = 3'd0;
        step();
        chk_lamps("blank_entry", 5'b01001);

        // blink_half=4: 1111 0000 1111
        for (int i = 1; i < 12; i++) begin
            step();
            chk($sformatf("blink4_%0d", i), {31'd0, lamp_yel}, {31'd0, ((i / 4) % 2) == 0});
        end
        // blink_half=0 behaves as 1: toggles every cycle.
        blink_half = 16'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("blink0_%0d", i), {31'd0, lamp_yel}, {31'd0, (i % 2) == 1});
        end
        blink_half = 16'd4;

        fault_clr = 1'b1;
        step();
        chk("fault_clr", {31'd0, fault}, 32'd0);
        state_in  = 3'd7;
        state_vld = 1'b1;
        step();
        chk("fault_set_wins", {31'd0, fault}, 32'd1);
        chk("inv7_busy", {31'd0, busy}, 32'd0);
        fault_clr = 1'b0;
        state_vld = 1'b0;
        state_in  = 3'd0;

        // BLANK -> GREEN, then RED request into forced YELLOW, reset mid-dwell.
        min_dwell = 16'd2;
        state_in  = 3'd4;
        state_vld = 1'b1;
        step();
        state_vld = 1'b0;
        step();
        chk_lamps("to_green", 5'b00101);
        state_in  = 3'd2;
        state_vld = 1'b1;
        step();
        chk_lamps("grn_req_red", 5'b00111);
        state_vld = 1'b0;
        step();
        chk_lamps("forced_yel", 5'b01011);
        min_dwell = 16'd8;
        step();
        step();
        chk_lamps("yel_hold", 5'b01011);
        #2;
        prst = 1'b0;
        #1;
        chk_lamps("async_reset", 5'b10000);
        @(negedge pclk);
        prst = 1'b1;
        step();
        chk_lamps("post_reset", 5'b10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlc_lamp_drv.md
TLC_LAMP_DRV -- requirements
Module: tlc_lamp_drv

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the dwell and blink counters.
REQ-002 SHALL have port pclk, input, 1 bit, sole clock, rising edge.
REQ-003 SHALL have port prst, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port state_in, input, 3 bits, requested light state from the controller (OFF=0, BLANK=1, RED=2, YELLOW=3, GREEN=4).
REQ-005 SHALL have port state_vld, input, 1 bit, qualifies state_in for sampling on this edge.
REQ-006 SHALL have port min_dwell, input, CNT_W bits, minimum cycles an applied state is held.
REQ-007 SHALL have port blink_half, input, CNT_W bits, cycles per half-period of the BLANK blink.
REQ-008 SHALL have port fault_clr, input, 1 bit, clears the sticky fault flag.
REQ-009 SHALL have port lamp_red, output, 1 bit, red lamp drive.
REQ-010 SHALL have port lamp_yel, output, 1 bit, yellow lamp drive.
REQ-011 SHALL have port lamp_grn, output, 1 bit, green lamp drive.
REQ-012 SHALL have port busy, output, 1 bit, high while pending state differs from applied state.
REQ-013 SHALL have port fault, output, 1 bit, sticky invalid-request flag.

Function
REQ-014 SHALL hold registers: pending (3b), cur (applied state, 3b), dwell_cnt, blink_cnt, blink_q.
REQ-015 SHALL load pending from state_in on any edge with state_vld=1; the last request wins, and earlier requests not yet applied are dropped.
REQ-016 SHALL, for state_in codes 5-7, load pending with BLANK and set fault on the same edge.
REQ-017 SHALL increment dwell_cnt every cycle, saturating at all-ones, and clear it to 0 on every change of cur.
REQ-018 SHALL treat min_dwell=0 as 1 and blink_half=0 as 1.
REQ-019 SHALL update cur on an edge where pending!=cur and dwell_cnt>=effective min_dwell-1; lamps therefore change at the earliest one edge after the sampling edge.
REQ-020 SHALL, when cur=GREEN and pending is anything other than GREEN or YELLOW, set cur to YELLOW first and move to pending only after a further full dwell.
REQ-021 SHALL decode lamps combinationally from cur: RED to red, YELLOW to yel, GREEN to grn, OFF to all off, BLANK to yel=blink_q; at most one lamp is ever lit.
REQ-022 SHALL, on entry to BLANK, set blink_q=1 and blink_cnt=0, then toggle blink_q each time blink_cnt reaches effective blink_half-1, wrapping blink_cnt to 0.
REQ-023 SHALL drive busy = (pending!=cur), as a combinational output.
REQ-024 SHALL clear fault when fault_clr=1, unless an invalid code is sampled on the same edge, in which case set wins.
REQ-025 SHALL sample min_dwell and blink_half live each cycle; a change takes effect on the next comparison.

Reset
REQ-026 SHALL, while prst=0, force cur=pending=RED, dwell_cnt=0, blink_cnt=0, blink_q=0 and fault=0, giving lamp_red=1, lamp_yel=0, lamp_grn=0 and busy=0.
REQ-027 SHALL abandon any in-progress dwell or forced YELLOW when reset is asserted mid-operation; release is synchronous to pclk.

Configuration
REQ-028 SHALL, with TLC_LAMP_FB_EN defined, add input lamp_fb[2:0] ({red,yel,grn} sensed); a mismatch against the driven lamps for 4 consecutive cycles sets fault and forces pending to BLANK.
REQ-029 SHALL, without TLC_LAMP_FB_EN, have no lamp_fb port and set fault only on invalid codes.

Structure
REQ-030 SHALL place the state encoding constants and a 3-bit state typedef in shared package tlc_pkg, used by both the controller and this block.
REQ-031 SHALL implement the blink counter and blink_q in sub-module tlc_blink_gen (inputs enable, restart, half; output blink).

Verification
REQ-032 SHALL verify: reset, then state_in=YELLOW with vld and min_dwell=3 -> lamp_yel rises on the 3rd edge after reset release; busy is high until then.
REQ-033 SHALL verify: cur=GREEN with dwell met, request RED -> YELLOW for min_dwell=5 cycles, then RED; lamp_grn and lamp_red are never high together.
REQ-034 SHALL verify: request BLANK with blink_half=4 -> yel pattern 1111 0000 repeating; blink_half=0 -> toggles every cycle.
REQ-035 SHALL verify: state_in=6 -> fault=1 and BLANK; fault_clr pulse -> fault=0; fault_clr and another invalid code on the same edge -> fault stays 1.
REQ-036 SHALL verify: requests RED, GREEN, OFF on consecutive cycles within a dwell of 8 -> only OFF is applied after the dwell expires.
REQ-037 SHALL verify: prst asserted mid-dwell in forced YELLOW -> lamp_red=1 immediately, with no clock edge required.
